// File: rtl/fu_br_pipe.sv
// Two-stage pipelined branch unit: S1 captures the issued op, S2 holds the resolved
// result (direction, target, misprediction, link value) for ROB writeback and redirect.
`timescale 1ns/1ps
module fu_br_pipe #(
  parameter int XLEN      = 32,
  parameter int ROB_DEPTH = 16,
  parameter int OP_W      = 4,
  parameter int CNT_W     = 16,
  localparam int ROB_W    = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [XLEN-1:0]  issue_pc,
  input  logic [XLEN-1:0]  issue_imm,
  input  logic [XLEN-1:0]  issue_rs1,
  input  logic [XLEN-1:0]  issue_rs2,
  input  logic [ROB_W-1:0] issue_rob,
  input  logic             issue_pred_taken,
  input  logic [XLEN-1:0]  issue_pred_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROB_W-1:0] out_rob,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic             out_mispredict,
  output logic [XLEN-1:0]  out_wb_data,
  output logic             out_wb_valid,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BGE  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BLTU = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BGEU = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JALR = OP_W'(7);

  logic             s1_valid;
  logic [OP_W-1:0]  s1_op;
  logic [XLEN-1:0]  s1_pc, s1_imm, s1_rs1, s1_rs2, s1_pred_target;
  logic [ROB_W-1:0] s1_rob;
  logic             s1_pred_taken;

  logic             s1_adv, s2_adv, out_fire;
  logic             c_taken, c_mispredict, c_wb_valid, c_is_cond;
  logic [XLEN-1:0]  c_target, c_wb_data, c_br_tgt, c_seq_pc, c_jalr_sum;

  // Valid/ready: a transfer happens on a rising edge where valid && ready; a stage
  // holding data advances only when the next stage is empty or is itself draining.
  assign s2_adv      = !out_valid || out_ready;
  assign s1_adv      = !s1_valid || s2_adv;
  assign issue_ready = s1_adv;
  assign out_fire    = out_valid && out_ready;

  assign redirect_valid = out_fire && out_mispredict;
  assign redirect_pc    = out_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid       <= 1'b0;
      s1_op          <= '0;
      s1_pc          <= '0;
      s1_imm         <= '0;
      s1_rs1         <= '0;
      s1_rs2         <= '0;
      s1_rob         <= '0;
      s1_pred_taken  <= 1'b0;
      s1_pred_target <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= issue_valid;
      if (issue_valid) begin
        s1_op          <= issue_op;
        s1_pc          <= issue_pc;
        s1_imm         <= issue_imm;
        s1_rs1         <= issue_rs1;
        s1_rs2         <= issue_rs2;
        s1_rob         <= issue_rob;
        s1_pred_taken  <= issue_pred_taken;
        s1_pred_target <= issue_pred_target;
      end
    end
  end

  always_comb begin
    c_taken    = 1'b0;
    c_is_cond  = 1'b0;
    c_wb_valid = 1'b0;
    c_br_tgt   = s1_pc + s1_imm;
    c_seq_pc   = s1_pc + XLEN'(4);
    c_jalr_sum = s1_rs1 + s1_imm;
    c_target   = c_seq_pc;
    case (s1_op)
      OP_BEQ:  begin c_is_cond = 1'b1; c_taken = (s1_rs1 == s1_rs2); end
      OP_BNE:  begin c_is_cond = 1'b1; c_taken = (s1_rs1 != s1_rs2); end
      OP_BLT:  begin c_is_cond = 1'b1; c_taken = ($signed(s1_rs1) < $signed(s1_rs2)); end
      OP_BGE:  begin c_is_cond = 1'b1; c_taken = ($signed(s1_rs1) >= $signed(s1_rs2)); end
      OP_BLTU: begin c_is_cond = 1'b1; c_taken = (s1_rs1 < s1_rs2); end
      OP_BGEU: begin c_is_cond = 1'b1; c_taken = (s1_rs1 >= s1_rs2); end
      OP_JAL:  begin c_taken = 1'b1; c_wb_valid = 1'b1; c_target = c_br_tgt; end
      OP_JALR: begin
        c_taken    = 1'b1;
        c_wb_valid = 1'b1;
        c_target   = {c_jalr_sum[XLEN-1:1], 1'b0};
      end
      default: ;  // undefined opcode resolves as not taken, falls through to pc+4
    endcase
    if (c_is_cond && c_taken) c_target = c_br_tgt;
    c_wb_data    = c_wb_valid ? c_seq_pc : '0;
    c_mispredict = (c_taken != s1_pred_taken) ||
                   (c_taken && (c_target != s1_pred_target));
  end

  // S2 fields change only when the stage advances, which keeps out_* stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_rob        <= '0;
      out_taken      <= 1'b0;
      out_target     <= '0;
      out_mispredict <= 1'b0;
      out_wb_data    <= '0;
      out_wb_valid   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_rob        <= s1_rob;
        out_taken      <= c_taken;
        out_target     <= c_target;
        out_mispredict <= c_mispredict;
        out_wb_data    <= c_wb_data;
        out_wb_valid   <= c_wb_valid;
      end
    end
  end

  // A handshake completing in a flush cycle still retires, so it is still counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (out_fire) begin
      if (stat_branches != {CNT_W{1'b1}})
        stat_branches <= stat_branches + CNT_W'(1);
      if (out_mispredict && (stat_mispredicts != {CNT_W{1'b1}}))
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fu_br_pipe.sv
// Bench for fu_br_pipe: directed cases plus random traffic checked by a scoreboard;
// a second instance with 2-bit counters shares the stimulus to exercise saturation.
`timescale 1ns/1ps
module tb_fu_br_pipe;

  localparam int XLEN = 32;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_W = 4;
  localparam int OP_W = 4;
  localparam int CNT_W = 16;
  localparam int SCNT_W = 2;

  localparam logic [3:0] OP_BEQ = 4'd0, OP_BNE = 4'd1, OP_BLT = 4'd2, OP_BGE = 4'd3,
                         OP_BLTU = 4'd4, OP_BGEU = 4'd5, OP_JAL = 4'd6, OP_JALR = 4'd7;

  typedef struct packed {
    logic [ROB_W-1:0] rob;
    logic             taken;
    logic [XLEN-1:0]  target;
    logic             mp;
    logic [XLEN-1:0]  wb_data;
    logic             wb_valid;
    logic [31:0]      cyc;
  } exp_t;

  logic              clk, rst_n, flush, issue_valid, out_ready;
  logic              issue_ready, out_valid, out_taken, out_mispredict, out_wb_valid, redirect_valid;
  logic [OP_W-1:0]   issue_op;
  logic [XLEN-1:0]   issue_pc, issue_imm, issue_rs1, issue_rs2, issue_pred_target;
  logic [ROB_W-1:0]  issue_rob, out_rob;
  logic              issue_pred_taken;
  logic [XLEN-1:0]   out_target, out_wb_data, redirect_pc;
  logic [CNT_W-1:0]  stat_branches, stat_mispredicts;

  logic              sm_issue_ready, sm_out_valid, sm_out_taken, sm_out_mispredict;
  logic              sm_out_wb_valid, sm_redirect_valid;
  logic [ROB_W-1:0]  sm_out_rob;
  logic [XLEN-1:0]   sm_out_target, sm_out_wb_data, sm_redirect_pc;
  logic [SCNT_W-1:0] sm_stat_branches, sm_stat_mispredicts;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  exp_t        h;
  logic [31:0] cyc = 0;
  logic [15:0] m_br, m_mp;
  logic [1:0]  s_br, s_mp;
  logic        prev_hold, exp_ov, exp_rv;
  logic [95:0] prev_snap;
  logic [3:0]  rob_ctr = 0;

  fu_br_pipe #(.XLEN(XLEN), .ROB_DEPTH(ROB_DEPTH), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rob(issue_rob), .issue_pred_taken(issue_pred_taken),
    .issue_pred_target(issue_pred_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_rob(out_rob), .out_taken(out_taken),
    .out_target(out_target), .out_mispredict(out_mispredict), .out_wb_data(out_wb_data),
    .out_wb_valid(out_wb_valid), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  fu_br_pipe #(.XLEN(XLEN), .ROB_DEPTH(ROB_DEPTH), .OP_W(OP_W), .CNT_W(SCNT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(sm_issue_ready), .issue_op(issue_op),
    .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rob(issue_rob), .issue_pred_taken(issue_pred_taken),
    .issue_pred_target(issue_pred_target),
    .out_valid(sm_out_valid), .out_ready(out_ready), .out_rob(sm_out_rob),
    .out_taken(sm_out_taken), .out_target(sm_out_target),
    .out_mispredict(sm_out_mispredict), .out_wb_data(sm_out_wb_data),
    .out_wb_valid(sm_out_wb_valid), .redirect_valid(sm_redirect_valid),
    .redirect_pc(sm_redirect_pc),
    .stat_branches(sm_stat_branches), .stat_mispredicts(sm_stat_mispredicts)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] pc, imm, rs1, rs2,
                                 input logic pt, input logic [31:0] ptgt,
                                 input logic [3:0] rob, input logic [31:0] c);
    exp_t e;
    logic t;
    logic [31:0] tgt;
    case (op)
      OP_BEQ:  t = (rs1 == rs2);
      OP_BNE:  t = (rs1 != rs2);
      OP_BLT:  t = ($signed(rs1) < $signed(rs2));
      OP_BGE:  t = ($signed(rs1) >= $signed(rs2));
      OP_BLTU: t = (rs1 < rs2);
      OP_BGEU: t = (rs1 >= rs2);
      OP_JAL, OP_JALR: t = 1'b1;
      default: t = 1'b0;
    endcase
    if (op == OP_JAL) tgt = pc + imm;
    else if (op == OP_JALR) begin tgt = rs1 + imm; tgt[0] = 1'b0; end
    else tgt = t ? pc + imm : pc + 32'd4;
    e.rob      = rob;
    e.taken    = t;
    e.target   = tgt;
    e.mp       = (t != pt) || (t && (tgt != ptgt));
    e.wb_valid = (op == OP_JAL) || (op == OP_JALR);
    e.wb_data  = e.wb_valid ? pc + 32'd4 : 32'd0;
    e.cyc      = c;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] pc, imm, rs1, rs2,
                        input logic pt, input logic [31:0] ptgt);
    issue_op = op; issue_pc = pc; issue_imm = imm; issue_rs1 = rs1; issue_rs2 = rs2;
    issue_pred_taken = pt; issue_pred_target = ptgt;
    issue_rob = rob_ctr;
    rob_ctr++;
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] pc, imm, rs1, rs2,
                      input logic pt, input logic [31:0] ptgt);
    int n;
    set_op(op, pc, imm, rs1, rs2, pt, ptgt);
    issue_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!issue_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("issue_accept", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_br = 0; m_mp = 0; s_br = 0; s_mp = 0;
      prev_hold = 1'b0;
    end else begin
      cyc++;
      chk("stat_branches", stat_branches, m_br);
      chk("stat_mispredicts", stat_mispredicts, m_mp);
      chk("sat_branches", sm_stat_branches, s_br);
      chk("sat_mispredicts", sm_stat_mispredicts, s_mp);
      exp_ov = (exp_q.size() > 0) && (exp_q[0].cyc + 32'd2 <= cyc);
      chk("out_valid", out_valid, exp_ov);
      chk("issue_ready", issue_ready, !(exp_q.size() == 2 && !out_ready));
      if (prev_hold)
        chk("held_outputs", {out_rob, out_taken, out_target, out_mispredict, out_wb_data,
                             out_wb_valid}, prev_snap);
      if (out_valid && exp_q.size() > 0) begin
        h = exp_q[0];
        chk("out_rob", out_rob, h.rob);
        chk("out_taken", out_taken, h.taken);
        chk("out_target", out_target, h.target);
        chk("out_mispredict", out_mispredict, h.mp);
        chk("out_wb_data", out_wb_data, h.wb_data);
        chk("out_wb_valid", out_wb_valid, h.wb_valid);
      end
      exp_rv = out_valid && out_ready && (exp_q.size() > 0) && exp_q[0].mp;
      chk("redirect_valid", redirect_valid, exp_rv);
      if (exp_rv) chk("redirect_pc", redirect_pc, exp_q[0].target);
      if (out_valid && out_ready && exp_q.size() > 0) begin
        h = exp_q.pop_front();
        if (m_br != 16'hFFFF) m_br++;
        if (s_br != 2'b11) s_br++;
        if (h.mp) begin
          if (m_mp != 16'hFFFF) m_mp++;
          if (s_mp != 2'b11) s_mp++;
        end
      end
      if (issue_valid && issue_ready && !flush)
        exp_q.push_back(model(issue_op, issue_pc, issue_imm, issue_rs1, issue_rs2,
                              issue_pred_taken, issue_pred_target, issue_rob, cyc));
      if (flush) exp_q.delete();
      prev_hold = out_valid && !out_ready && !flush;
      prev_snap = {out_rob, out_taken, out_target, out_mispredict, out_wb_data, out_wb_valid};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt, first, last, lows, rdr, acc_blocked;
    logic [31:0] pc, imm;
    rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; out_ready = 1'b1;
    set_op(4'd0, 0, 0, 0, 0, 1'b0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {out_rob, out_taken, out_target, out_mispredict, out_wb_data,
                        out_wb_valid}, 0);
    chk("rst_redirect", {redirect_valid, redirect_pc}, 0);
    chk("rst_stats", {stat_branches, stat_mispredicts}, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_issue_ready", issue_ready, 1);
    tick();

    // signed vs unsigned compare on the same operands
    send(OP_BLT, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h120);
    @(negedge clk); @(negedge clk);
    chk("blt_valid", out_valid, 1);
    chk("blt_taken", out_taken, 1);
    chk("blt_target", out_target, 32'h120);
    chk("blt_mispredict", out_mispredict, 0);
    chk("blt_redirect", redirect_valid, 0);
    tick();
    send(OP_BLTU, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h120);
    @(negedge clk); @(negedge clk);
    chk("bltu_taken", out_taken, 0);
    chk("bltu_target", out_target, 32'h104);
    chk("bltu_mispredict", out_mispredict, 1);
    chk("bltu_redirect", redirect_valid, 1);
    chk("bltu_redirect_pc", redirect_pc, 32'h104);
    tick();

    send(OP_JALR, 32'h200, 32'h4, 32'h1001, 32'h0, 1'b0, 32'h0);
    @(negedge clk); @(negedge clk);
    chk("jalr_target", out_target, 32'h1004);
    chk("jalr_wb_valid", out_wb_valid, 1);
    chk("jalr_wb_data", out_wb_data, 32'h204);
    chk("jalr_mispredict", out_mispredict, 1);
    tick();

    // back-to-back, all correctly predicted
    cnt = 0; first = -1; last = -1;
    fork
      begin
        send(OP_BEQ,  32'h300, 32'h40,        32'h5,         32'h5,         1'b1, 32'h340);
        send(OP_BNE,  32'h304, 32'h10,        32'h5,         32'h5,         1'b0, 32'h0);
        send(OP_BGE,  32'h308, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, 32'h300);
        send(OP_BGEU, 32'h30C, 32'h100,       32'h1,         32'hFFFF_FFFF, 1'b0, 32'h0);
      end
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            cnt++;
            if (first < 0) first = k;
            last = k;
          end
        end
      end
    join
    chk("b2b_count", cnt, 4);
    chk("b2b_first", first, 2);
    chk("b2b_span", last - first, 3);
    tick();
    @(negedge clk);
    chk("b2b_stat_branches", stat_branches, 7);
    tick();

    // backpressure: first op mispredicted, held while out_ready is low
    out_ready = 1'b0;
    lows = 0; rdr = 0; acc_blocked = 0;
    fork
      begin
        send(OP_BEQ, 32'h400, 32'h80,  32'h9, 32'h9, 1'b0, 32'h0);
        send(OP_BNE, 32'h404, 32'h8,   32'h1, 32'h2, 1'b1, 32'h40C);
        send(OP_JAL, 32'h408, 32'h100, 32'h0, 32'h0, 1'b1, 32'h508);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 14; k++) begin
          @(negedge clk);
          if (!issue_ready) lows++;
          if (redirect_valid) rdr++;
          if (issue_valid && issue_ready && !out_ready) acc_blocked++;
        end
      end
    join
    chk("bp_accepts_blocked", acc_blocked, 2);
    chk("bp_ready_dropped", lows > 0, 1);
    chk("bp_redirect_pulses", rdr, 1);
    tick();

    // flush with both stages full and a new op offered, no handshake
    out_ready = 1'b0;
    send(OP_JAL, 32'h500, 32'h40, 32'h0, 32'h0, 1'b0, 32'h0);
    send(OP_BEQ, 32'h504, 32'h40, 32'h1, 32'h1, 1'b1, 32'h544);
    set_op(OP_JAL, 32'h508, 32'h40, 32'h0, 32'h0, 1'b0, 32'h0);
    issue_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0; issue_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_redirect", redirect_valid, 0);
    end
    chk("flush_stat_branches", stat_branches, 10);
    chk("flush_stat_mispredicts", stat_mispredicts, 3);
    tick();

    // flush in the same cycle as a completing mispredicted handshake
    send(OP_JAL, 32'h600, 32'h20, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    set_op(OP_BNE, 32'h700, 32'h8, 32'h1, 32'h2, 1'b0, 32'h0);
    issue_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_hs_redirect", redirect_valid, 1);
    chk("flush_hs_redirect_pc", redirect_pc, 32'h620);
    chk("flush_hs_issue_ready", issue_ready, 1);
    tick();
    flush = 1'b0; issue_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush_hs_dropped", out_valid, 0);
    chk("flush_hs_stat_branches", stat_branches, 11);
    chk("flush_hs_stat_mispredicts", stat_mispredicts, 4);
    chk("sat_mid_mispredicts", sm_stat_mispredicts, 3);
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      pc  = $urandom & 32'hFFFF_FFFC;
      imm = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 'h7FF))
                                        : 32'd0 - 32'($urandom_range(0, 'h7FF));
      set_op(4'($urandom_range(0, 9)), pc, imm, $urandom, 32'd0, 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 2) == 0) issue_rs2 = issue_rs1; else issue_rs2 = $urandom;
      case ($urandom_range(0, 2))
        0: issue_pred_target = pc + imm;
        1: issue_pred_target = pc + 32'd4;
        default: issue_pred_target = $urandom;
      endcase
      issue_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      tick();
    end
    issue_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    // asynchronous reset with ops in flight
    set_op(OP_JAL, 32'h800, 32'h10, 32'h0, 32'h0, 1'b0, 32'h0);
    issue_valid = 1'b1;
    tick();
    set_op(OP_BEQ, 32'h804, 32'h10, 32'h3, 32'h3, 1'b0, 32'h0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_stats", {stat_branches, stat_mispredicts}, 0);
    chk("arst_sat_stats", {sm_stat_branches, sm_stat_mispredicts}, 0);
    chk("arst_redirect", redirect_valid, 0);
    issue_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // saturation: five mispredicted JALs
    for (int i = 0; i < 5; i++)
      send(OP_JAL, 32'h900 + 32'(i * 4), 32'h40, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (4) tick();
    @(negedge clk);
    chk("sat_mispredicts", sm_stat_mispredicts, 3);
    chk("sat_branches", sm_stat_branches, 3);
    chk("wide_mispredicts", stat_mispredicts, 5);
    chk("wide_branches", stat_branches, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
